// File: rtl/stack_arbiter_if.sv
// Requester-side handshake bundle for stack_arbiter: two request ports and
// their single-cycle response pulses.
interface stack_arbiter_if #(parameter int WIDTH = 32);
  logic             req0_valid, req1_valid;
  logic             req0_op,    req1_op;
  logic [WIDTH-1:0] req0_data,  req1_data;
  logic             req0_ready, req1_ready;
  logic             resp0_valid, resp1_valid;
  logic [WIDTH-1:0] resp0_data,  resp1_data;
  logic             resp0_err,   resp1_err;

  modport master (
    output req0_valid, req1_valid, req0_op, req1_op, req0_data, req1_data,
    input  req0_ready, req1_ready, resp0_valid, resp1_valid,
           resp0_data, resp1_data, resp0_err, resp1_err
  );

  modport slave (
    input  req0_valid, req1_valid, req0_op, req1_op, req0_data, req1_data,
    output req0_ready, req1_ready, resp0_valid, resp1_valid,
           resp0_data, resp1_data, resp0_err, resp1_err
  );
endinterface

// File: rtl/stack_arbiter.sv
// Round-robin arbiter sharing one stack block between two requesters; one
// command in flight, occupancy tracked here and committed at accept.
module stack_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 15
) (
  input  logic             clk,
  input  logic             rst,
  stack_arbiter_if.slave   req_if,
  output logic             stk_push_en,
  output logic             stk_pop_en,
  output logic [WIDTH-1:0] stk_data_in,
  input  logic [WIDTH-1:0] stk_data_out,
  output logic [4:0]       count,
  output logic             full,
  output logic             empty
);
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_e;

  state_e           state_q, state_d;
  logic             port_q, op_q, err_q, last_q;
  logic             push_en_q, pop_en_q;
  logic [WIDTH-1:0] din_q, rdata_q;
  logic [4:0]       count_q;

  logic             gnt, accept, sel_op, acc_err;
  logic [WIDTH-1:0] sel_data;

  // Tie goes to the port that did not win last time.
  always_comb begin
    gnt = 1'b0;
    if (req_if.req0_valid && req_if.req1_valid) gnt = ~last_q;
    else if (req_if.req1_valid)                 gnt = 1'b1;
  end

  assign accept   = (state_q == IDLE) && (req_if.req0_valid || req_if.req1_valid);
  assign sel_op   = gnt ? req_if.req1_op   : req_if.req0_op;
  assign sel_data = gnt ? req_if.req1_data : req_if.req0_data;
  assign acc_err  = sel_op ? (count_q == DEPTH_C) : (count_q == 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = (!op_q && !err_q) ? CAPTURE : RESP;
      CAPTURE: state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port_q    <= 1'b0;
      op_q      <= 1'b0;
      err_q     <= 1'b0;
      last_q    <= 1'b1;
      push_en_q <= 1'b0;
      pop_en_q  <= 1'b0;
      din_q     <= '0;
      rdata_q   <= '0;
      count_q   <= 5'd0;
    end else begin
      push_en_q <= 1'b0;
      pop_en_q  <= 1'b0;
      din_q     <= '0;
      if (accept) begin
        port_q    <= gnt;
        op_q      <= sel_op;
        err_q     <= acc_err;
        last_q    <= gnt;
        rdata_q   <= '0;
        push_en_q <= sel_op && !acc_err;
        pop_en_q  <= !sel_op && !acc_err;
        din_q     <= (sel_op && !acc_err) ? sel_data : '0;
        // Occupancy is committed here, not when the stack sees the command.
        if (!acc_err) count_q <= sel_op ? count_q + 5'd1 : count_q - 5'd1;
      end
      if (state_q == CAPTURE) rdata_q <= stk_data_out;
    end
  end

  always_comb begin
    req_if.req0_ready  = accept && !gnt;
    req_if.req1_ready  = accept && gnt;
    req_if.resp0_valid = (state_q == RESP) && !port_q;
    req_if.resp1_valid = (state_q == RESP) && port_q;
    req_if.resp0_err   = req_if.resp0_valid && err_q;
    req_if.resp1_err   = req_if.resp1_valid && err_q;
    req_if.resp0_data  = req_if.resp0_valid ? rdata_q : '0;
    req_if.resp1_data  = req_if.resp1_valid ? rdata_q : '0;
  end

  assign stk_push_en = push_en_q;
  assign stk_pop_en  = pop_en_q;
  assign stk_data_in = din_q;
  assign count       = count_q;
  assign full        = (count_q == DEPTH_C);
  assign empty       = (count_q == 5'd0);
endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: transaction-level model (queue stack, latency per
// op kind, round-robin pointer) compared every cycle, plus directed scenarios.
module tb_stack_arbiter;
  localparam int W = 32;
  localparam int D = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stack_arbiter_if #(.WIDTH(W)) bus();
  logic         push_en, pop_en, full, empty;
  logic [W-1:0] din;
  logic [W-1:0] dout = '0;
  logic [4:0]   count;

  stack_arbiter #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .req_if(bus),
    .stk_push_en(push_en), .stk_pop_en(pop_en),
    .stk_data_in(din), .stk_data_out(dout),
    .count(count), .full(full), .empty(empty)
  );

  // Stack block stand-in: registered data_out on pop.
  logic [W-1:0] mem [16];
  logic [3:0]   sp;
  always @(posedge clk or posedge rst) begin
    if (rst) sp <= 4'd0;
    else if (push_en) begin mem[sp] <= din; sp <= sp + 4'd1; end
    else if (pop_en) begin dout <= mem[sp - 4'd1]; sp <= sp - 4'd1; end
  end

  // Stimulus
  bit          v [2];
  bit          o [2];
  logic [31:0] d [2];
  bit          rand_en, hold_mode;
  int          push_pct;

  // Model
  int          m_age, m_lat, m_port;
  bit          m_op, m_err, m_last;
  logic [31:0] m_din, m_rdata;
  logic [31:0] m_stk [$];

  // Bookkeeping / observations of the DUT
  int          n_cmp, n_bad, cyc;
  int          seen_ready_cyc [2];
  int          grants [$];
  bit          obs_resp, obs_err, obs_push, obs_pop;
  logic [31:0] obs_data;

  task automatic drive_bus();
    bus.req0_valid = v[0]; bus.req0_op = o[0]; bus.req0_data = d[0];
    bus.req1_valid = v[1]; bus.req1_op = o[1]; bus.req1_data = d[1];
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int grant_of();
    if (v[0] && v[1]) return m_last ? 0 : 1;
    if (v[0]) return 0;
    if (v[1]) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_age = 0; m_lat = 0; m_port = 0; m_op = 0; m_err = 0;
    m_last = 1'b1; m_din = '0; m_rdata = '0;
    m_stk.delete();
    v[0] = 0; v[1] = 0; o[0] = 0; o[1] = 0; d[0] = '0; d[1] = '0;
    drive_bus();
  endtask

  task automatic check_outputs();
    int  g;
    bit  idle, issue_ok, rv;
    g        = grant_of();
    idle     = (m_age == 0);
    issue_ok = (m_age == 1) && !m_err;
    rv       = (m_age != 0) && (m_age == m_lat);
    chk("req0_ready", bus.req0_ready, idle && g == 0);
    chk("req1_ready", bus.req1_ready, idle && g == 1);
    chk("stk_push_en", push_en, issue_ok && m_op);
    chk("stk_pop_en", pop_en, issue_ok && !m_op);
    chk("stk_data_in", din, (issue_ok && m_op) ? m_din : 32'h0);
    chk("enables_exclusive", push_en & pop_en, 0);
    chk("resp0_valid", bus.resp0_valid, rv && m_port == 0);
    chk("resp1_valid", bus.resp1_valid, rv && m_port == 1);
    chk("resp0_err", bus.resp0_err, rv && m_port == 0 && m_err);
    chk("resp1_err", bus.resp1_err, rv && m_port == 1 && m_err);
    chk("resp0_data", bus.resp0_data, (rv && m_port == 0) ? m_rdata : 32'h0);
    chk("resp1_data", bus.resp1_data, (rv && m_port == 1) ? m_rdata : 32'h0);
    chk("count", count, m_stk.size());
    chk("full", full, m_stk.size() == D);
    chk("empty", empty, m_stk.size() == 0);
    for (int p = 0; p < 2; p++) begin
      if ((p == 0) ? bus.req0_ready : bus.req1_ready) begin
        grants.push_back(p);
        seen_ready_cyc[p] = cyc;
      end
    end
    if (push_en) obs_push = 1;
    if (pop_en)  obs_pop  = 1;
    if (bus.resp0_valid || bus.resp1_valid) begin
      obs_resp = 1;
      obs_err  = bus.resp0_valid ? bus.resp0_err  : bus.resp1_err;
      obs_data = bus.resp0_valid ? bus.resp0_data : bus.resp1_data;
    end
    cyc++;
  endtask

  task automatic commit(input bit acc, input int g);
    if (m_age != 0) begin
      m_age++;
      if (m_age > m_lat) m_age = 0;
    end else if (acc) begin
      m_port  = g;
      m_op    = o[g];
      m_last  = (g == 1);
      m_err   = m_op ? (m_stk.size() == D) : (m_stk.size() == 0);
      m_din   = (m_op && !m_err) ? d[g] : 32'h0;
      m_rdata = '0;
      if (!m_err) begin
        if (m_op) m_stk.push_back(d[g]);
        else      m_rdata = m_stk.pop_back();
      end
      m_lat = (m_op || m_err) ? 2 : 3;
      m_age = 1;
      v[g]  = 0;
    end
    for (int p = 0; p < 2; p++) begin
      if (!v[p] && hold_mode) begin
        v[p] = 1; o[p] = 1; d[p] = $urandom;
      end else if (!v[p] && rand_en && $urandom_range(0, 1) == 1) begin
        v[p] = 1;
        o[p] = ($urandom_range(0, 99) < push_pct);
        d[p] = $urandom;
      end
    end
    drive_bus();
  endtask

  task automatic cycle();
    int g;
    bit acc;
    @(negedge clk);
    check_outputs();
    g   = grant_of();
    acc = (m_age == 0) && (g >= 0);
    @(posedge clk);
    #1;
    commit(acc, g);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic do_op(input int p, input bit op, input logic [31:0] data);
    int k;
    obs_resp = 0; obs_err = 0; obs_push = 0; obs_pop = 0; obs_data = '0;
    v[p] = 1; o[p] = op; d[p] = data;
    drive_bus();
    for (k = 0; k < 12; k++) begin
      cycle();
      if (!v[p] && m_age == 0) break;
    end
    if (k == 12) chk("do_op_timeout", 1, 0);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    rand_en = 0; hold_mode = 0; push_pct = 50;
    seen_ready_cyc[0] = -100; seen_ready_cyc[1] = -100;
    rst = 1'b1;
    model_reset();
    #2;
    chk("reset_count", count, 0);
    chk("reset_empty", empty, 1);
    chk("reset_full", full, 0);
    chk("reset_push_en", push_en, 0);
    chk("reset_resp1_valid", bus.resp1_valid, 0);
    do_reset();

    // Push then pop on port 1 with exact timing.
    v[1] = 1; o[1] = 1; d[1] = 32'hA5A5_0001; drive_bus();
    cycle();
    chk("t1_issue_push_en", push_en, 1);
    chk("t1_count_1", count, 1);
    cycle();
    chk("t1_push_resp", {bus.resp1_valid, bus.resp1_err}, 2'b10);
    v[1] = 1; o[1] = 0; drive_bus();
    cycle();
    cycle();
    chk("t1_pop_en_pulse", pop_en, 1);
    chk("t1_count_0", count, 0);
    cycle();
    chk("t1_pop_en_drop", pop_en, 0);
    chk("t1_no_early_resp", bus.resp1_valid, 0);
    cycle();
    chk("t1_pop_resp_valid", bus.resp1_valid, 1);
    chk("t1_pop_resp_data", bus.resp1_data, 32'hA5A5_0001);
    chk("t1_pop_resp_err", bus.resp1_err, 0);
    repeat (2) cycle();

    // Both ports push continuously: alternating grants.
    do_reset();
    grants.delete();
    hold_mode = 1;
    repeat (12) cycle();
    hold_mode = 0;
    v[0] = 0; v[1] = 0; drive_bus();
    repeat (3) cycle();
    chk("t2_grant_count", grants.size(), 4);
    if (grants.size() >= 4)
      for (int i = 0; i < 4; i++) chk("t2_grant_order", grants[i], i % 2);
    chk("t2_count", count, 4);

    // Fill to DEPTH, then overflow.
    do_reset();
    for (int i = 0; i < D; i++) do_op(0, 1, $urandom);
    chk("t3_full", full, 1);
    chk("t3_count15", count, 15);
    do_op(0, 1, 32'hDEAD_BEEF);
    chk("t3_ovf_resp", obs_resp, 1);
    chk("t3_ovf_err", obs_err, 1);
    chk("t3_ovf_no_push", obs_push, 0);
    chk("t3_count_stays", count, 15);

    // Underflow from empty.
    do_reset();
    do_op(1, 0, 32'h0);
    chk("t4_udf_resp", obs_resp, 1);
    chk("t4_udf_err", obs_err, 1);
    chk("t4_udf_data", obs_data, 0);
    chk("t4_udf_no_pop", obs_pop, 0);
    chk("t4_count", count, 0);

    // Reset during ISSUE of a push.
    do_reset();
    v[0] = 1; o[0] = 1; d[0] = 32'h1234_5678; drive_bus();
    cycle();
    chk("t5_issue_push_en", push_en, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_push_drop", push_en, 0);
    chk("t5_count", count, 0);
    chk("t5_empty", empty, 1);
    model_reset();
    @(posedge clk); #1; rst = 1'b0;
    obs_resp = 0;
    repeat (3) cycle();
    chk("t5_no_resp", obs_resp, 0);
    grants.delete();
    v[0] = 1; o[0] = 1; d[0] = 32'h1; v[1] = 1; o[1] = 1; d[1] = 32'h2; drive_bus();
    repeat (2) cycle();
    chk("t5_grant_seen", grants.size() > 0, 1);
    if (grants.size() > 0) chk("t5_tie_port0", grants[0], 0);
    repeat (8) cycle();

    // Port 1 waits out a port-0 pop.
    do_reset();
    do_op(0, 1, 32'hCAFE_0000);
    seen_ready_cyc[0] = -100; seen_ready_cyc[1] = -100;
    v[0] = 1; o[0] = 0; drive_bus();
    cycle();
    v[1] = 1; o[1] = 1; d[1] = 32'h55; drive_bus();
    for (int k = 0; k < 10 && v[1]; k++) cycle();
    chk("t6_ready1_gap", seen_ready_cyc[1] - seen_ready_cyc[0], 4);
    repeat (4) cycle();

    // Random traffic with shifting push bias.
    do_reset();
    rand_en = 1;
    for (int ph = 0; ph < 4; ph++) begin
      push_pct = (ph % 2 == 0) ? 85 - ph * 5 : 20;
      repeat (400) cycle();
    end
    rand_en = 0;
    v[0] = 0; v[1] = 0; drive_bus();
    repeat (6) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
